// File: rtl/viterbi_pkg.sv
// viterbi_pkg: trellis constants and helpers for the K=3, rate-1/2 (7,5) Viterbi decoder.
package viterbi_pkg;
  localparam int K = 3;
  localparam int NUM_STATES = 4;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;
  typedef logic [1:0] state_t;
  function automatic state_t next_state(state_t s, logic u);
    return {u, s[1]};
  endfunction
  function automatic logic [1:0] coded_bits(state_t s, logic u);
    return {^({u, s} & G0), ^({u, s} & G1)};
  endfunction
endpackage

// File: rtl/viterbi_acs_if.sv
// viterbi_acs_if: symbol-pair input and decision-word output streams of the ACS stage.
interface viterbi_acs_if #(
  parameter int SYM_W = 8,
  parameter int PM_W  = 11
);
  logic             in_valid, in_ready, in_first, in_last;
  logic [SYM_W-1:0] in_sym0, in_sym1;
  logic             out_valid, out_ready, out_last;
  logic [3:0]       out_dec;
  logic [1:0]       out_best;
  logic [15:0]      out_step;
  logic [4*PM_W-1:0] out_pm;
  modport master (
    output in_valid, in_first, in_last, in_sym0, in_sym1, out_ready,
    input  in_ready, out_valid, out_last, out_dec, out_best, out_step, out_pm
  );
  modport slave (
    input  in_valid, in_first, in_last, in_sym0, in_sym1, out_ready,
    output in_ready, out_valid, out_last, out_dec, out_best, out_step, out_pm
  );
endinterface

// File: rtl/viterbi_bmu.sv
// viterbi_bmu: branch metrics for the four {c0,c1} hypotheses of one sign-magnitude symbol pair.
module viterbi_bmu #(
  parameter int SYM_W = 8
) (
  input  logic [SYM_W-1:0]            sym0,
  input  logic [SYM_W-1:0]            sym1,
  output logic [3:0][SYM_W-1:0]       bm
);
  logic [1:0][SYM_W-1:0] cost0, cost1;
  // A negative symbol votes for bit 0, so it only costs its magnitude when bit 1 is expected.
  always_comb begin
    cost0[0] = sym0[SYM_W-1] ? '0 : {1'b0, sym0[SYM_W-2:0]};
    cost0[1] = sym0[SYM_W-1] ? {1'b0, sym0[SYM_W-2:0]} : '0;
    cost1[0] = sym1[SYM_W-1] ? '0 : {1'b0, sym1[SYM_W-2:0]};
    cost1[1] = sym1[SYM_W-1] ? {1'b0, sym1[SYM_W-2:0]} : '0;
  end
  for (genvar i = 0; i < 4; i++) begin : g_bm
    assign bm[i] = cost0[i/2] + cost1[i%2];
  end
endmodule

// File: rtl/viterbi_acs.sv
// viterbi_acs: 4-state add-compare-select with renormalised path metrics and a
// registered decision word behind a valid/ready handshake.
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int SYM_W = 8,
  parameter int PM_W  = 11
) (
  input logic         clk,
  input logic         rst_n,
  viterbi_acs_if.slave bus
);
  localparam logic [PM_W-1:0] INIT = PM_W'(1) << (PM_W - 2);
  localparam logic [3:0][PM_W-1:0] PM_INIT = {INIT, INIT, INIT, {PM_W{1'b0}}};
  logic [3:0][SYM_W-1:0] bm;
  logic [3:0][PM_W-1:0]  src, cand0, cand1, pm_new, pm_rn, pm_d, pm_q;
  logic [3:0]            dec_new, dec_d, dec_q;
  logic [1:0]            b01, b23, best_rn, best_d, best_q;
  logic [15:0]           step_d, step_q;
  logic                  valid_d, valid_q, last_d, last_q, accept, renorm;

  viterbi_bmu #(.SYM_W(SYM_W)) u_bmu (.sym0(bus.in_sym0), .sym1(bus.in_sym1), .bm(bm));

  assign src = bus.in_first ? PM_INIT : pm_q;

  // Lane n: predecessors {n[0],0} and {n[0],1}, both entered with input bit u = n[1].
  for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
    localparam state_t P0 = state_t'((n % 2) * 2);
    localparam state_t P1 = state_t'((n % 2) * 2 + 1);
    localparam logic   U  = 1'(n / 2);
    localparam logic [1:0] B0 = coded_bits(P0, U);
    localparam logic [1:0] B1 = coded_bits(P1, U);
    assign cand0[n]   = src[P0] + PM_W'(bm[B0]);
    assign cand1[n]   = src[P1] + PM_W'(bm[B1]);
    assign dec_new[n] = cand1[n] < cand0[n];
    assign pm_new[n]  = dec_new[n] ? cand1[n] : cand0[n];
  end

  always_comb begin
    renorm = pm_new[0][PM_W-1] & pm_new[1][PM_W-1] & pm_new[2][PM_W-1] & pm_new[3][PM_W-1];
    for (int s = 0; s < NUM_STATES; s++)
      pm_rn[s] = renorm ? {1'b0, pm_new[s][PM_W-2:0]} : pm_new[s];
    b01     = pm_rn[1] < pm_rn[0] ? 2'd1 : 2'd0;
    b23     = pm_rn[3] < pm_rn[2] ? 2'd3 : 2'd2;
    best_rn = pm_rn[b23] < pm_rn[b01] ? b23 : b01;
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    valid_d = accept ? 1'b1 : (bus.out_ready ? 1'b0 : valid_q);
    pm_d    = accept ? pm_rn : pm_q;
    dec_d   = accept ? dec_new : dec_q;
    best_d  = accept ? best_rn : best_q;
    last_d  = accept ? bus.in_last : last_q;
    step_d  = accept ? (bus.in_first ? 16'd0 : step_q + 16'd1) : step_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pm_q    <= PM_INIT;
      dec_q   <= '0;
      best_q  <= '0;
      last_q  <= 1'b0;
      step_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pm_q    <= pm_d;
      dec_q   <= dec_d;
      best_q  <= best_d;
      last_q  <= last_d;
      step_q  <= step_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_pm    = pm_q;
  assign bus.out_dec   = dec_q;
  assign bus.out_best  = best_q;
  assign bus.out_last  = last_q;
  assign bus.out_step  = step_q;
endmodule

// File: tb/tb_viterbi_acs.sv
// tb_viterbi_acs: directed and model-checked scenarios for the Viterbi ACS stage.
module tb_viterbi_acs;
  localparam int SYM_W = 8;
  localparam int PM_W  = 11;
  localparam int INIT  = 512;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  viterbi_acs_if #(.SYM_W(SYM_W), .PM_W(PM_W)) bus ();
  viterbi_acs #(.SYM_W(SYM_W), .PM_W(PM_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  function automatic int pm(input int s);
    return int'(bus.out_pm[s*PM_W +: PM_W]);
  endfunction

  task automatic do_step(input logic [7:0] a, input logic [7:0] b, input logic f, input logic l);
    bus.in_valid = 1'b1;
    bus.in_sym0  = a;
    bus.in_sym1  = b;
    bus.in_first = f;
    bus.in_last  = l;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset;
    int exp_pm[4];
    exp_pm = '{0, INIT, INIT, INIT};
    bus.in_valid = 0; bus.in_first = 0; bus.in_last = 0;
    bus.in_sym0 = 0; bus.in_sym1 = 0; bus.out_ready = 1;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (pm(s) !== exp_pm[s]) begin errors++; $display("FAIL reset_pm[%0d] got=%0d exp=%0d", s, pm(s), exp_pm[s]); end
    end
    checks++;
    if ({bus.out_dec, bus.out_best, bus.out_last, bus.out_step} !== 23'd0) begin
      errors++; $display("FAIL reset_fields dec=%b best=%0d last=%0b step=%0d exp all 0",
                         bus.out_dec, bus.out_best, bus.out_last, bus.out_step);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_first;
    int exp_pm[4];
    exp_pm = '{0, 520, 16, 520};
    do_step(8'h88, 8'h88, 1'b1, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%0b exp=1", bus.out_valid); end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (pm(s) !== exp_pm[s]) begin errors++; $display("FAIL first_pm[%0d] got=%0d exp=%0d", s, pm(s), exp_pm[s]); end
    end
    checks++;
    if (bus.out_dec !== 4'b0000) begin errors++; $display("FAIL first_dec got=%b exp=0000", bus.out_dec); end
    checks++;
    if (bus.out_best !== 2'd0) begin errors++; $display("FAIL first_best got=%0d exp=0", bus.out_best); end
    checks++;
    if (bus.out_step !== 16'd0) begin errors++; $display("FAIL first_step got=%0d exp=0", bus.out_step); end
  endtask

  task automatic test_backpressure;
    int exp_pm[4];
    exp_pm = '{0, 520, 16, 520};
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_sym0 = 8'h08; bus.in_sym1 = 8'h88; bus.in_first = 0; bus.in_last = 0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%0b exp=0", bus.in_ready); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_step !== 16'd0 || bus.out_dec !== 4'b0000)
        begin errors++; $display("FAIL bp_hold cyc=%0d valid=%0b step=%0d dec=%b exp valid=1 step=0 dec=0000",
                                 c, bus.out_valid, bus.out_step, bus.out_dec); end
      for (int s = 0; s < 4; s++) begin
        checks++;
        if (pm(s) !== exp_pm[s]) begin errors++; $display("FAIL bp_pm cyc=%0d s=%0d got=%0d exp=%0d", c, s, pm(s), exp_pm[s]); end
      end
    end
    bus.out_ready = 1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_step !== 16'd1)
      begin errors++; $display("FAIL bp_accept valid=%0b step=%0d exp valid=1 step=1", bus.out_valid, bus.out_step); end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%0b exp=0", bus.out_valid); end
  endtask

  task automatic test_noiseless;
    logic [1:0] code[6];
    int exp_best[6];
    logic [3:0] dec[6];
    logic [1:0] st;
    logic [5:0] msg;
    code = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    exp_best = '{2, 1, 2, 3, 1, 0};
    for (int t = 0; t < 6; t++) begin
      do_step(code[t][1] ? 8'h08 : 8'h88, code[t][0] ? 8'h08 : 8'h88, t == 0, t == 5);
      dec[t] = bus.out_dec;
      checks++;
      if (int'(bus.out_best) !== exp_best[t]) begin errors++; $display("FAIL noiseless_best t=%0d got=%0d exp=%0d", t, bus.out_best, exp_best[t]); end
      checks++;
      if (pm(exp_best[t]) !== 0) begin errors++; $display("FAIL noiseless_minpm t=%0d got=%0d exp=0", t, pm(exp_best[t])); end
    end
    checks++;
    if (bus.out_last !== 1'b1 || bus.out_step !== 16'd5)
      begin errors++; $display("FAIL noiseless_last last=%0b step=%0d exp last=1 step=5", bus.out_last, bus.out_step); end
    st = 2'd0;
    for (int t = 5; t >= 0; t--) begin
      msg[5-t] = st[1];
      st = {st[0], dec[t][st]};
    end
    checks++;
    if (msg !== 6'b101100) begin errors++; $display("FAIL noiseless_traceback got=%b exp=101100", msg); end
  endtask

  task automatic test_renorm;
    int m[4], mn[4];
    int dmin, mmin, off, prev_off, renorms, cost0, cost1, bmv, s1, s0, ns, cand;
    logic [3:0] mdec;
    logic [7:0] a, b;
    logic c0, c1;
    int mbest;
    m = '{0, INIT, INIT, INIT};
    renorms = 0;
    prev_off = 0;
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      mn = '{32'h7fffffff, 32'h7fffffff, 32'h7fffffff, 32'h7fffffff};
      mdec = '0;
      for (int s = 0; s < 4; s++)
        for (int u = 0; u < 2; u++) begin
          s1 = s / 2; s0 = s % 2;
          c0 = 1'(u ^ s1 ^ s0);
          c1 = 1'(u ^ s0);
          cost0 = (a[7] == c0) ? int'(a[6:0]) : 0;
          cost1 = (b[7] == c1) ? int'(b[6:0]) : 0;
          bmv = cost0 + cost1;
          ns = u * 2 + s1;
          cand = m[s] + bmv;
          if (cand < mn[ns]) begin mn[ns] = cand; mdec[ns] = 1'(s0); end
        end
      m = mn;
      mmin = m[0]; mbest = 0;
      for (int s = 1; s < 4; s++) if (m[s] < mmin) begin mmin = m[s]; mbest = s; end
      do_step(a, b, i == 0, 1'b0);
      dmin = pm(0);
      for (int s = 1; s < 4; s++) if (pm(s) < dmin) dmin = pm(s);
      checks++;
      if (bus.out_dec !== mdec) begin errors++; $display("FAIL rand_dec i=%0d got=%b exp=%b", i, bus.out_dec, mdec); end
      checks++;
      if (int'(bus.out_best) !== mbest) begin errors++; $display("FAIL rand_best i=%0d got=%0d exp=%0d", i, bus.out_best, mbest); end
      for (int s = 0; s < 4; s++) begin
        checks++;
        if (pm(s) - dmin !== m[s] - mmin)
          begin errors++; $display("FAIL rand_pmdiff i=%0d s=%0d got=%0d exp=%0d", i, s, pm(s) - dmin, m[s] - mmin); end
      end
      off = mmin - dmin;
      if (off != prev_off) begin
        renorms++;
        checks++;
        if (off - prev_off !== 1024) begin errors++; $display("FAIL rand_renorm_step i=%0d got=%0d exp=1024", i, off - prev_off); end
      end
      prev_off = off;
    end
    checks++;
    if (renorms == 0) begin errors++; $display("FAIL rand_renorm_seen got=0 exp>0"); end
  endtask

  task automatic test_async_reset;
    do_step(8'h08, 8'h08, 1'b1, 1'b0);
    bus.out_ready = 0;
    do_step(8'h88, 8'h08, 1'b0, 1'b0);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%0b exp=0", bus.out_valid); end
    checks++;
    if (pm(0) !== 0 || pm(1) !== INIT || pm(2) !== INIT || pm(3) !== INIT)
      begin errors++; $display("FAIL areset_pm got=%0d,%0d,%0d,%0d exp=0,512,512,512", pm(0), pm(1), pm(2), pm(3)); end
    checks++;
    if (bus.out_step !== 16'd0) begin errors++; $display("FAIL areset_step got=%0d exp=0", bus.out_step); end
    @(posedge clk); #1;
    rst_n = 1;
    bus.out_ready = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_first();
    test_backpressure();
    test_noiseless();
    test_renorm();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
